// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between producers, the write arbiter and the async FIFO write side.
// master = producer/FIFO environment, slave = the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to let a grant hold the port for up to MAX_BURST beats.
//
// Handshake: a word moves from requester i when req_valid[i] && req_ready[i] at a rising wclk
// edge; req_ready only rises for the granted requester in XFER with the FIFO not full, and a
// requester must hold its word stable until accepted. winc/wdata are combinational from that.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_write_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef FIFO_ARB_BURST_EN
  localparam int BURST_LIMIT = MAX_BURST;
`else
  localparam int BURST_LIMIT = 1;
`endif
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(BURST_LIMIT);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  next_ptr;
  logic [CNT_W-1:0] beat_inc;
  logic             xfer;

  // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == XFER && !bus.wfull) bus.req_ready[grant_id_q] = 1'b1;
  end

  assign xfer      = |(bus.req_valid & bus.req_ready);
  assign bus.winc  = xfer;
  assign bus.wdata = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  // busy doubles as the externally visible FSM state.
  assign bus.busy     = (state_q == XFER);
  assign bus.grant_id = grant_id_q;

  assign next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
  assign beat_inc = beat_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // A dropped valid ends the grant even while the FIFO is stalling it.
        if (!bus.req_valid[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          beat_cnt_d = beat_inc;
          if (beat_inc == LIMIT) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table for arbitration/stall/drop cases,
// hand sequences for burst and asynchronous reset, scoreboard on every FIFO write.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic clk;
  logic rst_n;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .wclk  (clk),
    .wrst_n(rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every FIFO write must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.winc === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.wdata), 32'hFFFF_FFFF);
      else chk("wdata", 32'(bus.wdata), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] valid;
    logic       wfull;
    logic [3:0] ready;
    logic       winc;
    logic [1:0] grant;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  task automatic av(input logic [3:0] v, input logic f, input logic [3:0] r,
                    input logic w, input logic [1:0] g, input logic b);
    vec_t t;
    t.valid = v; t.wfull = f; t.ready = r; t.winc = w; t.grant = g; t.busy = b;
    vq.push_back(t);
  endtask

  task automatic set_lanes();
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

  initial begin
    int n;
    int beats;
    int stall_seen;
    logic acc;
    logic busy_prev;
    int beats_q[$];

    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.wfull     = 1'b0;
    set_lanes();

    // Reset held with every requester asking.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_winc",  32'(bus.winc), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'hA0);
    bus.req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

`ifndef FIFO_ARB_BURST_EN
    // Single-beat grants: round robin, stall, valid drop, wrap.
    av(4'hF, 0, 4'h0, 0, 0, 0);
    av(4'hF, 0, 4'h1, 1, 0, 1);
    av(4'hF, 0, 4'h0, 0, 0, 0);
    av(4'hF, 0, 4'h2, 1, 1, 1);
    av(4'hF, 0, 4'h0, 0, 1, 0);
    av(4'hF, 0, 4'h4, 1, 2, 1);
    av(4'hF, 0, 4'h0, 0, 2, 0);
    av(4'hF, 0, 4'h8, 1, 3, 1);
    av(4'hF, 0, 4'h0, 0, 3, 0);
    av(4'hF, 0, 4'h1, 1, 0, 1);
    av(4'hF, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) av(4'hF, 1, 4'h0, 0, 1, 1);
    av(4'hF, 0, 4'h2, 1, 1, 1);
    av(4'hF, 0, 4'h0, 0, 1, 0);
    av(4'hF, 0, 4'h4, 1, 2, 1);
    av(4'hF, 0, 4'h0, 0, 2, 0);
    av(4'hF, 1, 4'h0, 0, 3, 1);
    av(4'h7, 1, 4'h0, 0, 3, 1);
    av(4'h7, 0, 4'h0, 0, 3, 0);
    av(4'h7, 0, 4'h1, 1, 0, 1);
    av(4'h6, 0, 4'h0, 0, 0, 0);
    av(4'h0, 0, 4'h2, 0, 1, 1);
    av(4'h0, 0, 4'h0, 0, 1, 0);
    av(4'h9, 0, 4'h0, 0, 1, 0);
    av(4'h9, 0, 4'h8, 1, 3, 1);
    av(4'h9, 0, 4'h0, 0, 3, 0);
    av(4'h9, 0, 4'h1, 1, 0, 1);

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      bus.req_valid = vq[i].valid;
      bus.wfull     = vq[i].wfull;
      if (vq[i].winc) exp_q.push_back(8'hA0 + 8'(vq[i].grant));
      #3;
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vq[i].ready));
      chk($sformatf("v%0d_winc", i),  32'(bus.winc),      32'(vq[i].winc));
      chk($sformatf("v%0d_grant", i), 32'(bus.grant_id),  32'(vq[i].grant));
      chk($sformatf("v%0d_busy", i),  32'(bus.busy),      32'(vq[i].busy));
    end
`else
    // Requester 2 streams 10 words; a 5-cycle full stall lands inside the second burst.
    n = 0; beats = 0; stall_seen = 0; acc = 1'b0; busy_prev = 1'b0;
    for (int w = 0; w < 10; w++) exp_q.push_back(8'h50 + 8'(w));
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      if (acc) n++;
      bus.req_valid = (n < 10) ? 4'b0100 : 4'b0000;
      bus.req_data[2*DATA_WIDTH +: DATA_WIDTH] = 8'h50 + 8'(n);
      bus.wfull = (cyc >= 7 && cyc < 12);
      #3;
      acc = bus.req_ready[2] & bus.req_valid[2];
      if (bus.winc) beats++;
      if (bus.wfull && bus.busy) begin
        stall_seen++;
        chk("stall_winc",  32'(bus.winc), 32'd0);
        chk("stall_ready", 32'(bus.req_ready), 32'd0);
        chk("stall_grant", 32'(bus.grant_id), 32'd2);
      end
      if (busy_prev && !bus.busy) begin
        beats_q.push_back(beats);
        beats = 0;
      end
      busy_prev = bus.busy;
      if (n >= 9 && acc == 1'b0 && !bus.busy && beats_q.size() >= 3) break;
    end
    chk("burst_words", 32'(n + int'(acc)), 32'd10);
    chk("stall_cycles", 32'(stall_seen), 32'd5);
    chk("burst_count", 32'(beats_q.size()), 32'd3);
    if (beats_q.size() == 3) begin
      chk("burst0", 32'(beats_q[0]), 32'd4);
      chk("burst1", 32'(beats_q[1]), 32'd4);
      chk("burst2", 32'(beats_q[2]), 32'd2);
    end
    set_lanes();
`endif

    // Asynchronous reset while requester 2 is granted and about to write.
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0100;
    bus.wfull     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (bus.busy && bus.grant_id == 2'd2) break;
      @(posedge clk);
      #1;
    end
    chk("arst_setup", 32'(bus.busy && bus.grant_id == 2'd2), 32'd1);
    @(posedge clk);
    #1;
    bus.wfull = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_winc",  32'(bus.winc), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_grant", 32'(bus.grant_id), 32'd0);
    bus.req_valid = 4'h0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    bus.wfull     = 1'b1;
    @(posedge clk);
    #3;
    chk("arst_rr_grant", 32'(bus.grant_id), 32'd0);
    chk("arst_rr_busy",  32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 4'h0;
    bus.wfull     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("end_idle", 32'(bus.busy), 32'd0);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
